// File: rtl/ee357_alu_pkg.sv
// ee357_alu_pkg: ALU func codes, flag bit indices and func helpers shared by the result path.
package ee357_alu_pkg;
  typedef enum logic [5:0] {
    FN_SLL = 6'b000000,
    FN_SRL = 6'b000010,
    FN_SRA = 6'b000011,
    FN_JR  = 6'b001000,
    FN_ADD = 6'b100000,
    FN_SUB = 6'b100010,
    FN_AND = 6'b100100,
    FN_OR  = 6'b100101,
    FN_XOR = 6'b100110,
    FN_NOR = 6'b100111,
    FN_SLT = 6'b101010
  } alu_func_e;
  localparam int UOV  = 3;
  localparam int SOV  = 2;
  localparam int ZERO = 1;
  localparam int COUT = 0;
  function automatic logic is_addsub(input logic [5:0] f);
    return f == FN_ADD || f == FN_SUB;
  endfunction
endpackage

// File: rtl/ee357_result_fifo.sv
// ee357_result_fifo: generic circular-buffer FIFO; readiness depends only on registered count.
module ee357_result_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         in_ready,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push_ok, pop;
  assign in_ready = count < (AW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign out_data = out_valid ? mem[rd_ptr] : '0;
  assign push_ok = push && in_ready;
  assign pop = out_valid && out_ready;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/ee357_alu_result.sv
// ee357_alu_result: buffers ALU results for writeback, keeps sticky flags and, with OVF_TRAP_EN,
// drops ADD/SUB results with signed overflow and pulses ovf_trap instead.
module ee357_alu_result
  import ee357_alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_res,
  input  logic [3:0]        in_flags,
  input  logic [5:0]        in_func,
  input  logic [4:0]        in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [3:0]        out_flags,
  output logic [4:0]        out_dest,
  output logic [3:0]        sticky_flags,
  input  logic              flag_clr,
  output logic              ovf_trap,
  output logic [4:0]        trap_dest
);
  logic accept, trap;
  logic [3:0] acc_flags;
  assign accept = in_valid && in_ready;
  assign acc_flags = accept ? in_flags : 4'b0;
`ifdef OVF_TRAP_EN
  assign trap = accept && is_addsub(in_func) && in_flags[SOV];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovf_trap <= 1'b0;
      trap_dest <= '0;
    end else begin
      ovf_trap <= trap;
      trap_dest <= trap ? in_dest : trap_dest;
    end
`else
  logic unused_func;
  assign unused_func = ^in_func;
  assign trap = 1'b0;
  assign ovf_trap = 1'b0;
  assign trap_dest = '0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sticky_flags <= '0;
    else sticky_flags <= flag_clr ? acc_flags : sticky_flags | acc_flags;
  ee357_result_fifo #(.W(DATA_W + 9), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(in_valid && !trap),
    .push_data({in_flags, in_dest, in_res}),
    .in_ready(in_ready),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data({out_flags, out_dest, out_res})
  );
endmodule

// File: tb/tb_ee357_alu_result.sv
// tb_ee357_alu_result: scoreboard bench with a queue-based reference model, directed and random traffic.
module tb_ee357_alu_result;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, flag_clr = 0, ovf_trap;
  logic [31:0] in_res = 0, out_res;
  logic [3:0] in_flags = 0, out_flags, sticky_flags;
  logic [5:0] in_func = 0;
  logic [4:0] in_dest = 0, out_dest, trap_dest;
  int n_pass = 0, n_total = 0;

  typedef struct {logic [31:0] res; logic [3:0] flags; logic [4:0] dest;} ent_t;
  ent_t q[$];
  logic [3:0] sticky_m = 0;
  logic trap_m = 0;
  logic [4:0] tdest_m = 0;

  ee357_alu_result #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res),
    .in_flags(in_flags), .in_func(in_func), .in_dest(in_dest), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags), .out_dest(out_dest),
    .sticky_flags(sticky_flags), .flag_clr(flag_clr), .ovf_trap(ovf_trap), .trap_dest(trap_dest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference model: occupancy is the queue length; traps never enter the queue
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      sticky_m = 0;
      trap_m = 0;
      tdest_m = 0;
    end else begin
      int occ;
      bit acc, tr;
      logic [3:0] af;
      occ = q.size();
      acc = in_valid && occ < DEPTH;
      tr = 0;
`ifdef OVF_TRAP_EN
      tr = acc && (in_func == 6'b100000 || in_func == 6'b100010) && in_flags[2];
`endif
      af = acc ? in_flags : 4'b0;
      if (occ > 0 && out_ready) void'(q.pop_front());
      if (acc && !tr) q.push_back('{in_res, in_flags, in_dest});
      sticky_m = flag_clr ? af : (sticky_m | af);
      trap_m = tr;
      if (tr) tdest_m = in_dest;
    end

  always @(negedge clk)
    if (rst_n) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_res", 64'(out_res), 64'(q[0].res));
        chk("out_flags", 64'(out_flags), 64'(q[0].flags));
        chk("out_dest", 64'(out_dest), 64'(q[0].dest));
      end else chk("idle_zero", 64'({out_res, out_flags, out_dest}), 64'd0);
      chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      chk("sticky", 64'(sticky_flags), 64'(sticky_m));
      chk("ovf_trap", 64'(ovf_trap), 64'(trap_m));
      chk("trap_dest", 64'(trap_dest), 64'(tdest_m));
    end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] f,
                       input logic [5:0] fn, input logic [4:0] d);
    in_valid = v; in_res = r; in_flags = f; in_func = fn; in_dest = d;
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sticky", 64'(sticky_flags), 64'd0);
    rst_n = 1;
    cyc();
    // single entry, one-cycle latency
    out_ready = 1;
    drive(1, 32'h0033ccff, 4'b0000, 6'b100100, 5'd5);
    cyc();
    in_valid = 0;
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_res", 64'(out_res), 64'h0033ccff);
    chk("lat_dest", 64'(out_dest), 64'd5);
    cyc();
    chk("lat_empty", 64'(out_valid), 64'd0);
    // fill with back-pressure, third waits for a pop
    out_ready = 0;
    drive(1, 32'h1, 4'b0, 6'b100101, 5'd1); cyc();
    drive(1, 32'h2, 4'b0, 6'b100101, 5'd2); cyc();
    chk("full_not_ready", 64'(in_ready), 64'd0);
    drive(1, 32'h3, 4'b0, 6'b100101, 5'd3); cyc(); cyc();
    chk("full_head", 64'(out_res), 64'h1);
    out_ready = 1;
    cyc();
    chk("pop_only_ready", 64'(in_ready), 64'd1);
    chk("pop_only_head", 64'(out_res), 64'h2);
    cyc();
    in_valid = 0;
    chk("third_behind", 64'(out_res), 64'h3);
    cyc(); cyc();
    // sticky accumulation and clear
    flag_clr = 1; cyc(); flag_clr = 0;
    drive(1, 32'h10, 4'b1011, 6'b100100, 5'd4); cyc();
    drive(1, 32'h11, 4'b0001, 6'b100100, 5'd4); cyc();
    in_valid = 0;
    chk("sticky_or", 64'(sticky_flags), 64'b1011);
    flag_clr = 1;
    drive(1, 32'h12, 4'b1000, 6'b100100, 5'd4); cyc();
    flag_clr = 0; in_valid = 0;
    chk("sticky_clr", 64'(sticky_flags), 64'b1000);
    cyc(); cyc();
`ifdef OVF_TRAP_EN
    flag_clr = 1;
    drive(1, 32'h80000000, 4'b0100, 6'b100000, 5'd9); cyc();
    flag_clr = 0; in_valid = 0;
    chk("trap_pulse", 64'(ovf_trap), 64'd1);
    chk("trap_dest9", 64'(trap_dest), 64'd9);
    chk("trap_dropped", 64'(out_valid), 64'd0);
    chk("trap_sticky", 64'(sticky_flags), 64'b0100);
    cyc();
    chk("trap_one_cycle", 64'(ovf_trap), 64'd0);
`endif
    // reset with two entries buffered
    out_ready = 0;
    drive(1, 32'haa, 4'b0010, 6'b100100, 5'd7); cyc();
    drive(1, 32'hbb, 4'b0010, 6'b100100, 5'd8); cyc();
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_sticky", 64'(sticky_flags), 64'd0);
    cyc();
    rst_n = 1; out_ready = 1;
    repeat (4) cyc();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0] fns [4];
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b101010};
      drive(($urandom % 4) != 0, $urandom, 4'($urandom), fns[$urandom % 4], 5'($urandom));
      out_ready = ($urandom % 3) != 0;
      flag_clr = ($urandom % 8) == 0;
      cyc();
    end
    in_valid = 0; out_ready = 1; flag_clr = 0;
    repeat (DEPTH + 2) cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
